align_rx_tlps_param: RTL and testbench
======================================

ALIGN_RX_TLPS_PARAM -- requirements
Module: ofs_plat_host_chan_align_rx_tlps_param

Interface
REQ-001 Parameter TDATA_WIDTH, default 512: width of input and output data buses in bits; multiple of 64.
REQ-002 Parameter HDR_WIDTH, default 256: TLP header width in bits; multiple of 8 and strictly less than TDATA_WIDTH.
REQ-003 Derived parameters: KW = TDATA_WIDTH/8, HK = HDR_WIDTH/8, DW = TDATA_WIDTH-HDR_WIDTH, DK = DW/8.
REQ-004 clk  in  1  clock; every flop is clocked on the rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 rx_tvalid/rx_tready  in/out  1/1  source beat handshake.
REQ-007 rx_tdata/rx_tkeep  in  TDATA_WIDTH/KW  source beat; tkeep is contiguous from bit 0.
REQ-008 rx_tlast/rx_tsop/rx_dm_mode  in  1/1/1  end of packet; start of packet, with the header at tdata[0]; DM (1) or PU (0) header.
REQ-009 hdr_tvalid/hdr_tready  out/in  1/1  header stream handshake.
REQ-010 hdr_tdata/hdr_dm_mode  out  HDR_WIDTH/1  extracted header and its mode.
REQ-011 data_tvalid/data_tready  out/in  1/1  payload stream handshake.
REQ-012 data_tdata/data_tkeep/data_tlast  out  TDATA_WIDTH/KW/1  payload realigned to bit 0.
REQ-013 err_sop_mid_pkt/err_no_sop  out  1/1  sticky error flags (see Configuration).
REQ-014 err_count  out  16  count of error events, saturating.

Function
REQ-015 FSM states: IDLE (expecting SOP), IN_PKT (carry register holds upper DW bits of the previous beat), DRAIN (emitting the final carry-only beat).
REQ-016 rx_tready = hdr_in_rdy && data_in_rdy && (state != DRAIN), where *_in_rdy is the space signal of each 2-entry output skid buffer.
REQ-017 On an accepted SOP beat, the block SHALL push {rx_tdata[HDR_WIDTH-1:0], rx_dm_mode} to the header skid and load carry <= rx_tdata[TDATA_WIDTH-1:HDR_WIDTH] and carry_keep <= rx_tkeep[KW-1:HK].
REQ-018 Accepted SOP beat with !tlast -> IN_PKT; with tlast && rx_tkeep[HK] -> DRAIN; with tlast && !rx_tkeep[HK] -> IDLE, and no data beat is produced (header-only TLP).
REQ-019 On an accepted non-SOP beat in IN_PKT, the block SHALL push data = {rx_tdata[HDR_WIDTH-1:0], carry} and keep = {rx_tkeep[HK-1:0], carry_keep}, then reload carry from the upper part of the beat.
REQ-020 The pushed beat's last = rx_tlast && !rx_tkeep[HK]; rx_tlast && rx_tkeep[HK] -> DRAIN; !rx_tlast -> stay in IN_PKT.
REQ-021 In DRAIN, when the data skid has space, the block SHALL push data = {HDR_WIDTH'0, carry}, keep = {HK'0, carry_keep}, last=1, then go to IDLE.
REQ-022 A non-SOP beat accepted in IDLE SHALL be consumed and discarded, and SHALL set the err_no_sop condition.
REQ-023 A SOP beat accepted in IN_PKT SHALL discard the carry (no tlast is emitted for the broken packet), start the new packet per REQ-017/018, and set the err_sop_mid_pkt condition.
REQ-024 Latency: an output becomes valid 1 cycle after its source beat is accepted, or 1 cycle after the DRAIN push.
REQ-025 Full throughput: with both sinks always ready, no bubbles except the single DRAIN cycle.
REQ-026 The skid outputs SHALL hold tdata/tkeep/tlast stable while tvalid && !tready.

Reset
REQ-027 While reset_n=0 at a clock edge: state <= IDLE; both skids emptied; hdr_tvalid=0, data_tvalid=0 and rx_tready=0 in the following cycle; err flags and err_count <= 0.
REQ-028 Reset asserted mid-packet SHALL discard the carry and any partial packet; no data_tlast is generated for that packet.
REQ-029 Carry and data registers are not reset.

Configuration
REQ-030 With macro OFS_PLAT_ALIGN_RX_TLPS_ERR_CHK_EN defined: err_sop_mid_pkt and err_no_sop are sticky until reset, and err_count increments once per error event, saturating at 16'hFFFF.
REQ-031 Without the macro: err_* outputs and err_count are tied to 0 and no error logic is compiled; the data-path behaviour of REQ-022/023 is unchanged.

Verification (TDATA_WIDTH=512, HDR_WIDTH=256)
REQ-032 SOP+last, keep=64'h0000_0000_FFFF_FFFF -> one header equal to tdata[255:0]; no data beat; FSM returns to IDLE.
REQ-033 SOP+last, keep=all ones -> header, then one data beat: tdata[255:0] = in[511:256], keep=64'h0000_0000_FFFF_FFFF, last=1; rx_tready=0 for exactly 1 cycle (DRAIN).
REQ-034 3-beat packet A,B,C, with C keep=64'h0000_0000_FFFF_FFFF -> 2 data beats: {B[255:0],A[511:256]} keep all ones last=0, then {C[255:0],B[511:256]} keep all ones last=1.
REQ-035 data_tready=0 for 5 cycles mid-packet -> rx_tready drops within 2 cycles; no beat is lost or duplicated; output is stable while stalled.
REQ-036 reset_n=0 for 1 cycle after beat A of a 3-beat packet -> no data output for A; the next packet is processed correctly from IDLE.
REQ-037 Macro defined: a non-SOP beat in IDLE, then a SOP in IN_PKT -> err_no_sop=1, err_sop_mid_pkt=1, err_count=2; without the macro all three read 0.

Source files
------------

// File: rtl/align_rx_tlps_param.sv
// Realigns RX TLP beats: splits the SOP header onto its own stream and shifts the payload down to bit 0.
// Optional error checking is compiled in with OFS_PLAT_ALIGN_RX_TLPS_ERR_CHK_EN.

module align_rx_tlps_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [W-1:0] mem_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;
  logic         push_s;
  logic         pop_s;

  assign in_rdy    = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = mem_r[rd_ptr_r];
  assign push_s    = in_valid && in_rdy;
  assign pop_s     = out_valid && out_ready;

  // occupancy and pointer tracking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage, left unreset on purpose
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

endmodule

module align_rx_tlps_param #(
  parameter int TDATA_WIDTH = 512,
  parameter int HDR_WIDTH   = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_tvalid,
  output logic                     rx_tready,
  input  logic [TDATA_WIDTH-1:0]   rx_tdata,
  input  logic [TDATA_WIDTH/8-1:0] rx_tkeep,
  input  logic                     rx_tlast,
  input  logic                     rx_tsop,
  input  logic                     rx_dm_mode,
  output logic                     hdr_tvalid,
  input  logic                     hdr_tready,
  output logic [HDR_WIDTH-1:0]     hdr_tdata,
  output logic                     hdr_dm_mode,
  output logic                     data_tvalid,
  input  logic                     data_tready,
  output logic [TDATA_WIDTH-1:0]   data_tdata,
  output logic [TDATA_WIDTH/8-1:0] data_tkeep,
  output logic                     data_tlast,
  output logic                     err_sop_mid_pkt,
  output logic                     err_no_sop,
  output logic [15:0]              err_count
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int HK = HDR_WIDTH / 8;
  localparam int DW = TDATA_WIDTH - HDR_WIDTH;
  localparam int DK = DW / 8;
  localparam int HSW = HDR_WIDTH + 1;
  localparam int DSW = TDATA_WIDTH + KW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  state_t              beat_nxt_s;
  logic                run_r;
  logic [DW-1:0]       carry_r;
  logic [DK-1:0]       carry_keep_r;

  logic                hdr_in_rdy_s;
  logic                data_in_rdy_s;
  logic                accept_s;
  logic                hdr_push_s;
  logic                data_push_s;
  logic                load_carry_s;
  logic [TDATA_WIDTH-1:0] data_in_s;
  logic [KW-1:0]       keep_in_s;
  logic                last_in_s;
  logic [HSW-1:0]      hdr_skid_out_s;
  logic [DSW-1:0]      data_skid_out_s;

  // run_r keeps rx_tready low for the cycle after any reset edge
  assign rx_tready = run_r && hdr_in_rdy_s && data_in_rdy_s && (state_r != ST_DRAIN);
  assign accept_s  = rx_tvalid && rx_tready;

  // state after the current beat, shared by SOP and continuation beats
  always_comb begin
    if (!rx_tlast) begin
      beat_nxt_s = ST_IN_PKT;
    end else if (rx_tkeep[HK]) begin
      beat_nxt_s = ST_DRAIN;
    end else begin
      beat_nxt_s = ST_IDLE;
    end
  end

  // push decode and next state
  always_comb begin
    hdr_push_s   = 1'b0;
    data_push_s  = 1'b0;
    load_carry_s = 1'b0;
    state_nxt_s  = state_r;
    data_in_s    = {rx_tdata[HDR_WIDTH-1:0], carry_r};
    keep_in_s    = {rx_tkeep[HK-1:0], carry_keep_r};
    last_in_s    = rx_tlast && !rx_tkeep[HK];
    case (state_r)
      ST_IDLE, ST_IN_PKT: begin
        // a SOP always restarts, silently dropping any carry of a broken packet
        if (accept_s && rx_tsop) begin
          hdr_push_s   = 1'b1;
          load_carry_s = 1'b1;
          state_nxt_s  = beat_nxt_s;
        end else if (accept_s && (state_r == ST_IN_PKT)) begin
          data_push_s  = 1'b1;
          load_carry_s = 1'b1;
          state_nxt_s  = beat_nxt_s;
        end else begin
          state_nxt_s  = state_r;
        end
      end
      ST_DRAIN: begin
        data_in_s = {{HDR_WIDTH{1'b0}}, carry_r};
        keep_in_s = {{HK{1'b0}}, carry_keep_r};
        last_in_s = 1'b1;
        if (data_in_rdy_s) begin
          data_push_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
    end
  end

  // carry of the upper part of the previous beat, not reset
  always_ff @(posedge clk) begin
    if (load_carry_s) begin
      carry_r      <= rx_tdata[TDATA_WIDTH-1:HDR_WIDTH];
      carry_keep_r <= rx_tkeep[KW-1:HK];
    end
  end

  align_rx_tlps_skid #(.W(HSW)) hdr_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (hdr_push_s),
    .in_data   ({rx_tdata[HDR_WIDTH-1:0], rx_dm_mode}),
    .in_rdy    (hdr_in_rdy_s),
    .out_valid (hdr_tvalid),
    .out_data  (hdr_skid_out_s),
    .out_ready (hdr_tready)
  );

  align_rx_tlps_skid #(.W(DSW)) data_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (data_push_s),
    .in_data   ({data_in_s, keep_in_s, last_in_s}),
    .in_rdy    (data_in_rdy_s),
    .out_valid (data_tvalid),
    .out_data  (data_skid_out_s),
    .out_ready (data_tready)
  );

  assign hdr_tdata   = hdr_skid_out_s[HSW-1:1];
  assign hdr_dm_mode = hdr_skid_out_s[0];
  assign data_tdata  = data_skid_out_s[DSW-1:KW+1];
  assign data_tkeep  = data_skid_out_s[KW:1];
  assign data_tlast  = data_skid_out_s[0];

`ifdef OFS_PLAT_ALIGN_RX_TLPS_ERR_CHK_EN
  logic        err_mid_ev_s;
  logic        err_no_sop_ev_s;
  logic        err_sop_mid_pkt_r;
  logic        err_no_sop_r;
  logic [15:0] err_count_r;

  assign err_mid_ev_s    = accept_s && rx_tsop && (state_r == ST_IN_PKT);
  assign err_no_sop_ev_s = accept_s && !rx_tsop && (state_r == ST_IDLE);

  // sticky error flags and saturating event counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_sop_mid_pkt_r <= 1'b0;
      err_no_sop_r      <= 1'b0;
      err_count_r       <= 16'd0;
    end else begin
      if (err_mid_ev_s)    err_sop_mid_pkt_r <= 1'b1;
      if (err_no_sop_ev_s) err_no_sop_r      <= 1'b1;
      if ((err_mid_ev_s || err_no_sop_ev_s) && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end
    end
  end

  assign err_sop_mid_pkt = err_sop_mid_pkt_r;
  assign err_no_sop      = err_no_sop_r;
  assign err_count       = err_count_r;
`else
  assign err_sop_mid_pkt = 1'b0;
  assign err_no_sop      = 1'b0;
  assign err_count       = 16'd0;
`endif

endmodule

// File: tb/tb_align_rx_tlps_param.sv
// Bench for align_rx_tlps_param: directed cases plus random packets checked against a byte-stream model.

module tb_align_rx_tlps_param;

  localparam int TW = 512;
  localparam int HW = 256;
  localparam int KW = 64;
  localparam int HK = 32;

  logic          clk;
  logic          reset_n;
  logic          rx_tvalid;
  logic          rx_tready;
  logic [TW-1:0] rx_tdata;
  logic [KW-1:0] rx_tkeep;
  logic          rx_tlast;
  logic          rx_tsop;
  logic          rx_dm_mode;
  logic          hdr_tvalid;
  logic          hdr_tready;
  logic [HW-1:0] hdr_tdata;
  logic          hdr_dm_mode;
  logic          data_tvalid;
  logic          data_tready;
  logic [TW-1:0] data_tdata;
  logic [KW-1:0] data_tkeep;
  logic          data_tlast;
  logic          err_sop_mid_pkt;
  logic          err_no_sop;
  logic [15:0]   err_count;

  align_rx_tlps_param #(.TDATA_WIDTH(TW), .HDR_WIDTH(HW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast), .rx_tsop(rx_tsop), .rx_dm_mode(rx_dm_mode),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready), .hdr_tdata(hdr_tdata), .hdr_dm_mode(hdr_dm_mode),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .err_sop_mid_pkt(err_sop_mid_pkt), .err_no_sop(err_no_sop), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } dbeat_t;

  logic [HW:0]   exp_hdr[$];
  logic [HW:0]   obs_hdr[$];
  dbeat_t        exp_dat[$];
  dbeat_t        obs_dat[$];
  logic [TW-1:0] pd[$];
  logic [KW-1:0] pk[$];

  int     checks = 0;
  int     errors = 0;
  int     hdr_mode = 1;
  int     data_mode = 1;
  int     data_stall_left = 0;
  int     stall_idx = 0;
  int     drop_at = -1;
  int     rdy_low_cnt = 0;
  logic   s_rx_tready, s_hdr_tvalid, s_data_tvalid;
  logic   held_v = 1'b0;
  dbeat_t held;

  task automatic do_check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic [TW-1:0] rnd_data(input int nbytes);
    logic [TW-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    for (int i = 0; i < KW; i++) if (i >= nbytes) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [KW-1:0] keep_of(input int nbytes);
    logic [KW-1:0] k;
    for (int i = 0; i < KW; i++) k[i] = (i < nbytes);
    return k;
  endfunction

  // One clock: choose sink readiness, sample mid-cycle, then wait for the next falling edge.
  task automatic cycle(output logic acc);
    hdr_tready  = pick(hdr_mode);
    data_tready = (data_stall_left > 0) ? 1'b0 : pick(data_mode);
    #1;
    acc           = rx_tvalid && rx_tready;
    s_rx_tready   = rx_tready;
    s_hdr_tvalid  = hdr_tvalid;
    s_data_tvalid = data_tvalid;
    if (!rx_tready) rdy_low_cnt++;
    if (data_stall_left > 0) begin
      if (!rx_tready && drop_at < 0) drop_at = stall_idx;
      stall_idx++;
      data_stall_left--;
    end
    if (held_v) do_check("data_stable", 640'({data_tvalid, data_tdata, data_tkeep, data_tlast}), 640'({1'b1, held}));
    held_v = reset_n && data_tvalid && !data_tready;
    held   = {data_tdata, data_tkeep, data_tlast};
    if (hdr_tvalid && hdr_tready) obs_hdr.push_back({hdr_tdata, hdr_dm_mode});
    if (data_tvalid && data_tready) obs_dat.push_back({data_tdata, data_tkeep, data_tlast});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    rx_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send_beat(input logic [TW-1:0] d, input logic [KW-1:0] k,
                           input logic sop, input logic last, input logic dm);
    logic acc;
    int   n = 0;
    rx_tvalid = 1'b1; rx_tdata = d; rx_tkeep = k; rx_tsop = sop; rx_tlast = last; rx_dm_mode = dm;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) do_check("accept_timeout", 640'(0), 640'(1));
    rx_tvalid = 1'b0;
  endtask

  // Packet of nb beats: all full except the last, which carries last_bytes bytes.
  task automatic gen_pkt(input int nb, input int last_bytes);
    pd.delete(); pk.delete();
    for (int b = 0; b < nb; b++) begin
      int nby = (b == nb - 1) ? last_bytes : KW;
      pd.push_back(rnd_data(nby));
      pk.push_back(keep_of(nby));
    end
  endtask

  // Model: valid bytes form one stream; the first HK bytes are the header, the rest is
  // re-chunked into KW-byte beats from byte 0 with last on the final chunk.
  task automatic model_and_send(input logic dm);
    logic [7:0]    bq[$];
    logic [HW-1:0] h;
    dbeat_t        db;
    for (int b = 0; b < pd.size(); b++)
      for (int i = 0; i < KW; i++) if (pk[b][i]) bq.push_back(pd[b][8*i +: 8]);
    for (int i = 0; i < HK; i++) h[8*i +: 8] = bq.pop_front();
    exp_hdr.push_back({h, dm});
    while (bq.size() > 0) begin
      db = '0;
      for (int i = 0; i < KW && bq.size() > 0; i++) begin
        db.d[8*i +: 8] = bq.pop_front();
        db.k[i] = 1'b1;
      end
      db.l = (bq.size() == 0);
      exp_dat.push_back(db);
    end
    for (int b = 0; b < pd.size(); b++)
      send_beat(pd[b], pk[b], b == 0, b == pd.size() - 1, dm);
  endtask

  task automatic settle(input string tag);
    logic acc;
    int   n = 0;
    rx_tvalid = 1'b0;
    while ((obs_hdr.size() < exp_hdr.size() || obs_dat.size() < exp_dat.size()) && n < 300) begin
      cycle(acc);
      n++;
    end
    idle(4);
    do_check({tag, "_hdr_count"}, 640'(obs_hdr.size()), 640'(exp_hdr.size()));
    do_check({tag, "_data_count"}, 640'(obs_dat.size()), 640'(exp_dat.size()));
    for (int i = 0; i < exp_hdr.size() && i < obs_hdr.size(); i++)
      do_check({tag, "_hdr"}, 640'(obs_hdr[i]), 640'(exp_hdr[i]));
    for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++)
      do_check({tag, "_data"}, 640'(obs_dat[i]), 640'(exp_dat[i]));
    exp_hdr.delete(); obs_hdr.delete(); exp_dat.delete(); obs_dat.delete();
  endtask

  initial begin
    logic          acc;
    logic [TW-1:0] d;
    reset_n = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0;
    rx_tlast = 1'b0; rx_tsop = 1'b0; rx_dm_mode = 1'b0; hdr_tready = 1'b0; data_tready = 1'b0;
    @(negedge clk);

    // reset state
    for (int i = 0; i < 3; i++) cycle(acc);
    do_check("rst_rx_tready", 640'(s_rx_tready), 640'(0));
    do_check("rst_hdr_tvalid", 640'(s_hdr_tvalid), 640'(0));
    do_check("rst_data_tvalid", 640'(s_data_tvalid), 640'(0));
    do_check("rst_err", 640'({err_sop_mid_pkt, err_no_sop, err_count}), 640'(0));
    reset_n = 1'b1;
    idle(2);
    do_check("run_rx_tready", 640'(s_rx_tready), 640'(1));

    // header-only TLP: no data beat and no DRAIN cycle
    rdy_low_cnt = 0;
    gen_pkt(1, HK);
    model_and_send(1'b1);
    settle("hdr_only");
    do_check("hdr_only_no_drain", 640'(rdy_low_cnt), 640'(0));

    // single full beat: header plus one drained data beat, one stall cycle
    rdy_low_cnt = 0;
    gen_pkt(1, KW);
    model_and_send(1'b0);
    settle("one_full");
    do_check("one_full_drain_cycles", 640'(rdy_low_cnt), 640'(1));

    // three beats, last one half full
    gen_pkt(3, HK);
    model_and_send(1'b1);
    settle("three_beat");

    // data sink stalled for 5 cycles mid-packet
    gen_pkt(6, KW);
    begin
      logic [7:0] bq[$];
      logic [HW-1:0] h;
      dbeat_t db;
      for (int b = 0; b < pd.size(); b++)
        for (int i = 0; i < KW; i++) if (pk[b][i]) bq.push_back(pd[b][8*i +: 8]);
      for (int i = 0; i < HK; i++) h[8*i +: 8] = bq.pop_front();
      exp_hdr.push_back({h, 1'b0});
      while (bq.size() > 0) begin
        db = '0;
        for (int i = 0; i < KW && bq.size() > 0; i++) begin
          db.d[8*i +: 8] = bq.pop_front();
          db.k[i] = 1'b1;
        end
        db.l = (bq.size() == 0);
        exp_dat.push_back(db);
      end
    end
    for (int b = 0; b < 6; b++) begin
      if (b == 2) begin
        data_stall_left = 5; stall_idx = 0; drop_at = -1;
      end
      send_beat(pd[b], pk[b], b == 0, b == 5, 1'b0);
    end
    settle("stall");
    do_check("stall_rdy_drop", 640'(drop_at >= 0 && drop_at <= 2), 640'(1));

    // reset right after the first beat of a packet: nothing of it may come out
    hdr_mode = 2; data_mode = 2;
    send_beat(rnd_data(KW), keep_of(KW), 1'b1, 1'b0, 1'b1);
    reset_n = 1'b0;
    cycle(acc);
    reset_n = 1'b1;
    cycle(acc);
    do_check("rst_mid_rx_tready", 640'(s_rx_tready), 640'(0));
    do_check("rst_mid_valids", 640'({s_hdr_tvalid, s_data_tvalid}), 640'(0));
    hdr_mode = 0; data_mode = 0;
    gen_pkt(2, 40);
    model_and_send(1'b0);
    settle("after_reset");

    // random packets with random backpressure
    for (int p = 0; p < 40; p++) begin
      int nb = $urandom_range(1, 4);
      gen_pkt(nb, (nb == 1) ? $urandom_range(HK, KW) : $urandom_range(1, KW));
      model_and_send(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    settle("random");

    // protocol errors: stray non-SOP beat, then a SOP inside an open packet
    hdr_mode = 1; data_mode = 1;
    send_beat(rnd_data(KW), keep_of(KW), 1'b0, 1'b1, 1'b0);
    d = rnd_data(KW);
    exp_hdr.push_back({d[HW-1:0], 1'b1});
    send_beat(d, keep_of(KW), 1'b1, 1'b0, 1'b1);
    d = rnd_data(HK);
    exp_hdr.push_back({d[HW-1:0], 1'b0});
    send_beat(d, keep_of(HK), 1'b1, 1'b1, 1'b0);
    settle("err_seq");
`ifdef OFS_PLAT_ALIGN_RX_TLPS_ERR_CHK_EN
    do_check("err_no_sop", 640'(err_no_sop), 640'(1));
    do_check("err_sop_mid_pkt", 640'(err_sop_mid_pkt), 640'(1));
    do_check("err_count", 640'(err_count), 640'(2));
`else
    do_check("err_no_sop", 640'(err_no_sop), 640'(0));
    do_check("err_sop_mid_pkt", 640'(err_sop_mid_pkt), 640'(0));
    do_check("err_count", 640'(err_count), 640'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
